// File: rtl/param_updown_counter.sv
`default_nettype none
// +------------------------------------------------------------------------------+
// | Module  : param_updown_counter                                               |
// | Brief   : Parametrised modulo-N up/down counter with parallel load,          |
// |           terminal-count decode, wrap pulse and sticky overflow flag.        |
// |           Define COUNTER_SATURATE_EN to hold at the limits instead of wrap.  |
// | Revision: 1.0 - initial release                                              |
// +------------------------------------------------------------------------------+
module param_updown_counter #(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 256
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             ack_overflow,
  output logic [WIDTH-1:0] count_out,
  output logic             terminal_count,
  output logic             wrap_pulse,
  output logic             overflow_sticky
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             wrap_q;
  logic             sticky_q;
  logic             limit_event;
  logic             at_max;
  logic             at_zero;

  assign at_max         = (count_q == MAX);
  assign at_zero        = (count_q == '0);
  assign terminal_count = up_down ? at_max : at_zero;

  // A step taken while terminal_count is high is the wrap (or saturation) event.
  always_comb begin
    count_d     = count_q;
    limit_event = 1'b0;
    if (load) begin
      count_d = (load_value > MAX) ? MAX : load_value;
    end else if (enable) begin
      limit_event = terminal_count;
`ifdef COUNTER_SATURATE_EN
      if (!terminal_count) begin
        count_d = up_down ? (count_q + ONE) : (count_q - ONE);
      end
`else
      if (terminal_count) begin
        count_d = up_down ? '0 : MAX;
      end else begin
        count_d = up_down ? (count_q + ONE) : (count_q - ONE);
      end
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      count_q  <= '0;
      wrap_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= limit_event;
      if (limit_event) begin
        sticky_q <= 1'b1;
      end else if (ack_overflow) begin
        sticky_q <= 1'b0;
      end
    end
  end

  assign count_out       = count_q;
  assign wrap_pulse      = wrap_q;
  assign overflow_sticky = sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_param_updown_counter.sv
`default_nettype none
// +------------------------------------------------------------------------------+
// | Module  : tb_param_updown_counter                                            |
// | Brief   : Self-checking bench: vector table, corner sequences, random run.   |
// | Revision: 1.0 - initial release                                              |
// +------------------------------------------------------------------------------+
module tb_param_updown_counter;

  localparam int M_A = 10;
  localparam int M_B = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH=8, MODULUS=10
  logic       a_clear = 1'b0, a_enable = 1'b0, a_up = 1'b0, a_load = 1'b0, a_ack = 1'b0;
  logic [7:0] a_load_value = '0;
  logic [7:0] a_count;
  logic       a_tc, a_wrap, a_sticky;

  // Instance B: WIDTH=8, MODULUS=256
  logic       b_clear = 1'b0, b_enable = 1'b0, b_up = 1'b0, b_load = 1'b0, b_ack = 1'b0;
  logic [7:0] b_load_value = '0;
  logic [7:0] b_count;
  logic       b_tc, b_wrap, b_sticky;

  param_updown_counter #(.WIDTH(8), .MODULUS(M_A)) dut_a (
    .clock(clk), .clear(a_clear), .enable(a_enable), .up_down(a_up), .load(a_load),
    .load_value(a_load_value), .ack_overflow(a_ack), .count_out(a_count),
    .terminal_count(a_tc), .wrap_pulse(a_wrap), .overflow_sticky(a_sticky)
  );

  param_updown_counter #(.WIDTH(8), .MODULUS(M_B)) dut_b (
    .clock(clk), .clear(b_clear), .enable(b_enable), .up_down(b_up), .load(b_load),
    .load_value(b_load_value), .ack_overflow(b_ack), .count_out(b_count),
    .terminal_count(b_tc), .wrap_pulse(b_wrap), .overflow_sticky(b_sticky)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model for instance A, stated in terms of modular arithmetic.
  int m_count  = 0;
  bit m_wrap   = 0;
  bit m_sticky = 0;

  task automatic model_step(input bit cl, en, ud, ld, input int lv, input bit ak);
    bit at_limit;
    if (cl) begin
      m_count = 0; m_wrap = 0; m_sticky = 0;
    end else if (ld) begin
      m_count = (lv > M_A - 1) ? M_A - 1 : lv;
      m_wrap  = 0;
      if (ak) m_sticky = 0;
    end else if (en) begin
      at_limit = ud ? (m_count == M_A - 1) : (m_count == 0);
`ifdef COUNTER_SATURATE_EN
      if (!at_limit) m_count = ud ? m_count + 1 : m_count - 1;
`else
      m_count = ud ? (m_count + 1) % M_A : (m_count + M_A - 1) % M_A;
`endif
      m_wrap = at_limit;
      if (at_limit) m_sticky = 1;
      else if (ak) m_sticky = 0;
    end else begin
      m_wrap = 0;
      if (ak) m_sticky = 0;
    end
  endtask

  task automatic apply(input bit cl, en, ud, ld, input int lv, input bit ak);
    @(negedge clk);
    a_clear = cl; a_enable = en; a_up = ud; a_load = ld; a_load_value = lv[7:0]; a_ack = ak;
    @(posedge clk);
    model_step(cl, en, ud, ld, lv, ak);
    #1;
    check("count", int'(a_count), m_count);
    check("wrap_pulse", int'(a_wrap), int'(m_wrap));
    check("overflow_sticky", int'(a_sticky), int'(m_sticky));
    check("terminal_count", int'(a_tc), int'(ud ? (m_count == M_A - 1) : (m_count == 0)));
  endtask

  typedef struct {
    bit cl, en, ud, ld;
    int lv;
    bit ak;
    int e_cnt;
    bit e_wrap, e_sticky, e_tc;
  } vec_t;

  vec_t tbl[10];

  initial begin
    //            cl en ud ld  lv  ak  cnt w  s  tc
    tbl[0] = '{1, 0, 0, 0,   0, 0,  0, 0, 0, 1};
    tbl[1] = '{0, 0, 1, 1, 200, 0,  9, 0, 0, 1};
    tbl[2] = '{0, 1, 1, 1,   3, 0,  3, 0, 0, 0};
    tbl[3] = '{0, 1, 1, 0,   0, 0,  4, 0, 0, 0};
    tbl[4] = '{0, 0, 1, 1,   9, 0,  9, 0, 0, 1};
`ifdef COUNTER_SATURATE_EN
    tbl[5] = '{0, 1, 1, 0,   0, 0,  9, 1, 1, 1};
    tbl[6] = '{0, 1, 0, 0,   0, 0,  8, 0, 1, 0};
    tbl[7] = '{0, 0, 0, 0,   0, 1,  8, 0, 0, 0};
`else
    tbl[5] = '{0, 1, 1, 0,   0, 0,  0, 1, 1, 0};
    tbl[6] = '{0, 1, 0, 0,   0, 0,  9, 1, 1, 0};
    tbl[7] = '{0, 0, 0, 0,   0, 1,  9, 0, 0, 0};
`endif
    tbl[8] = '{1, 1, 1, 1,   5, 0,  0, 0, 0, 0};
    tbl[9] = '{0, 0, 0, 0,   0, 0,  0, 0, 0, 1};

    for (int i = 0; i < 10; i++) begin
      apply(tbl[i].cl, tbl[i].en, tbl[i].ud, tbl[i].ld, tbl[i].lv, tbl[i].ak);
      check($sformatf("tbl%0d_count", i), int'(a_count), tbl[i].e_cnt);
      check($sformatf("tbl%0d_wrap", i), int'(a_wrap), int'(tbl[i].e_wrap));
      check($sformatf("tbl%0d_sticky", i), int'(a_sticky), int'(tbl[i].e_sticky));
      check($sformatf("tbl%0d_tc", i), int'(a_tc), int'(tbl[i].e_tc));
    end

    // Clear mid-count with load and enable asserted.
    apply(0, 0, 1, 1, 7, 0);
    apply(0, 1, 1, 0, 0, 0);
    apply(1, 1, 1, 1, 3, 0);
    check("clear_overrides", int'(a_count), 0);

    // Ack on a wrap edge: set wins; ack on the next quiet edge clears.
    apply(0, 0, 0, 1, 0, 0);
    apply(0, 1, 0, 0, 0, 0);
    apply(0, 0, 0, 1, 0, 0);
    apply(0, 1, 0, 0, 0, 1);
    check("ack_on_wrap_sticky", int'(a_sticky), 1);
    apply(0, 0, 0, 0, 0, 1);
    check("ack_after_wrap_sticky", int'(a_sticky), 0);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
            ($urandom_range(0, 7) == 0), int'($urandom_range(0, 255)),
            ($urandom_range(0, 7) == 0));
    end

    // Instance B: full-range run of 300 enabled up-counts after a 2-cycle clear.
    @(negedge clk);
    b_clear = 1; b_enable = 1; b_up = 1; b_load = 1; b_load_value = 8'd77;
    repeat (2) @(posedge clk);
    #1;
    check("b_reset_count", int'(b_count), 0);
    check("b_reset_wrap", int'(b_wrap), 0);
    check("b_reset_sticky", int'(b_sticky), 0);
    @(negedge clk);
    b_clear = 0; b_load = 0;
    for (int k = 1; k <= 300; k++) begin
      int e_cnt;
      @(posedge clk);
      #1;
`ifdef COUNTER_SATURATE_EN
      e_cnt = (k > 255) ? 255 : k;
      check("b_run_wrap", int'(b_wrap), int'(k >= 256));
`else
      e_cnt = k % 256;
      check("b_run_wrap", int'(b_wrap), int'(k == 256));
`endif
      check("b_run_count", int'(b_count), e_cnt);
      check("b_run_sticky", int'(b_sticky), int'(k >= 256));
    end

    // Instance B: step down from 0.
    @(negedge clk);
    b_enable = 0; b_load = 1; b_load_value = 8'd0;
    @(posedge clk);
    #1;
    check("b_load0_count", int'(b_count), 0);
    check("b_load0_tc", int'(b_tc), 0);
    @(negedge clk);
    b_load = 0; b_enable = 1; b_up = 0;
    #1;
    check("b_down_tc_at0", int'(b_tc), 1);
    @(posedge clk);
    #1;
`ifdef COUNTER_SATURATE_EN
    check("b_down_from0", int'(b_count), 0);
`else
    check("b_down_from0", int'(b_count), 255);
`endif
    check("b_down_wrap", int'(b_wrap), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
